// File: rtl/mips_cpu_bus.sv
// Multicycle MIPS-I subset CPU on a single Avalon-style memory bus (FETCH/EXEC/MEM/HALT).
// Define MIPS_VAR_SHIFT_EN to implement SLLV/SRLV/SRAV; otherwise they execute as NOP.
module mips_cpu_bus #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d, ir_q, ir_d;
  logic [31:0] regs_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val, simm, zimm, pc_plus4, pc_plus8, br_target, mem_addr;
  logic        is_store, halt_fetch;

  assign opcode    = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign shamt     = ir_q[10:6];
  assign funct     = ir_q[5:0];
  assign rs_val    = regs_q[rs];
  assign rt_val    = regs_q[rt];
  assign simm      = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zimm      = {16'h0000, ir_q[15:0]};
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_plus8  = pc_q + 32'd8;
  assign br_target = pc_plus4 + {simm[29:0], 2'b00};
  assign mem_addr  = (rs_val + simm) & 32'hFFFF_FFFC;
  assign is_store  = (opcode == 6'h2b);
  // PC of zero at fetch means the program returned to address 0: stop instead of fetching.
  assign halt_fetch = (state_q == StFetch) && (pc_q == 32'd0);

  // Gated by reset so the first fetch is visible as soon as reset is released.
  assign active      = reset && (state_q != StHalt) && !halt_fetch;
  assign read        = reset && (((state_q == StFetch) && !halt_fetch) ||
                                 ((state_q == StMem) && !is_store));
  assign write       = reset && (state_q == StMem) && is_store;
  assign address     = (state_q == StMem) ? mem_addr : pc_q;
  assign writedata   = ((state_q == StMem) && is_store) ? rt_val : 32'd0;
  assign byteenable  = 4'b1111;
  assign register_v0 = regs_q[2];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    ir_d     = ir_q;
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = 32'd0;
    unique case (state_q)
      StFetch: begin
        if (halt_fetch) begin
          state_d = StHalt;
        end else if (!waitrequest) begin
          ir_d    = readdata;
          state_d = StExec;
        end
      end
      StExec: begin
        pc_d    = npc_q;
        npc_d   = npc_q + 32'd4;
        state_d = StFetch;
        case (opcode)
          6'h00: begin
            rf_we = 1'b1;
            case (funct)
              6'h00: rf_wdata = rt_val << shamt;
              6'h02: rf_wdata = rt_val >> shamt;
              6'h03: rf_wdata = $signed(rt_val) >>> shamt;
`ifdef MIPS_VAR_SHIFT_EN
              6'h04: rf_wdata = rt_val << rs_val[4:0];
              6'h06: rf_wdata = rt_val >> rs_val[4:0];
              6'h07: rf_wdata = $signed(rt_val) >>> rs_val[4:0];
`endif
              6'h08: begin
                rf_we = 1'b0;
                npc_d = rs_val;
              end
              6'h09: begin
                rf_wdata = pc_plus8;
                npc_d    = rs_val;
              end
              6'h21: rf_wdata = rs_val + rt_val;
              6'h23: rf_wdata = rs_val - rt_val;
              6'h24: rf_wdata = rs_val & rt_val;
              6'h25: rf_wdata = rs_val | rt_val;
              6'h26: rf_wdata = rs_val ^ rt_val;
              6'h2a: rf_wdata = {31'd0, $signed(rs_val) < $signed(rt_val)};
              6'h2b: rf_wdata = {31'd0, rs_val < rt_val};
              default: rf_we = 1'b0;
            endcase
          end
          6'h02: npc_d = {pc_plus4[31:28], ir_q[25:0], 2'b00};
          6'h03: begin
            npc_d    = {pc_plus4[31:28], ir_q[25:0], 2'b00};
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_plus8;
          end
          6'h04: if (rs_val == rt_val) npc_d = br_target;
          6'h05: if (rs_val != rt_val) npc_d = br_target;
          6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            case (opcode)
              6'h09:   rf_wdata = rs_val + simm;
              6'h0a:   rf_wdata = {31'd0, $signed(rs_val) < $signed(simm)};
              6'h0b:   rf_wdata = {31'd0, rs_val < simm};
              6'h0c:   rf_wdata = rs_val & zimm;
              6'h0d:   rf_wdata = rs_val | zimm;
              6'h0e:   rf_wdata = rs_val ^ zimm;
              default: rf_wdata = {ir_q[15:0], 16'h0000};
            endcase
          end
          6'h23, 6'h2b: state_d = StMem;
          default: ;
        endcase
      end
      StMem: begin
        if (!waitrequest) begin
          if (!is_store) begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            rf_wdata = readdata;
          end
          state_d = StFetch;
        end
      end
      StHalt: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_VECTOR;
      npc_q   <= RESET_VECTOR + 32'd4;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Self-checking bench for mips_cpu_bus: directed programs plus random programs checked against
// an instruction-level reference model; the memory slave inserts configurable wait states.
module tb_mips_cpu_bus;

  localparam logic [31:0] RV = 32'hBFC00000;
`ifdef MIPS_VAR_SHIFT_EN
  localparam bit VarShift = 1'b1;
`else
  localparam bit VarShift = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;
  logic        active, write, read;
  logic [31:0] register_v0, address, writedata;
  logic [3:0]  byteenable;

  mips_cpu_bus #(.RESET_VECTOR(RV)) dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] img [256];
  logic [31:0] mem [256];
  logic [31:0] mdl_mem [256];
  logic [31:0] mdl_reg [32];
  int          stall_mode = 0;
  int          stall_left = 0;
  logic        stalled_prev = 1'b0;
  logic [69:0] prev_bus = '0;
  logic        pend_wr = 1'b0;
  int          pend_idx = 0;
  logic [31:0] pend_data = 32'd0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  function automatic int reload();
    if (stall_mode == 0) return 0;
    if (stall_mode == 1) return 3;
    return rnd(0, 3);
  endfunction

  // Memory slave: decides waitrequest/readdata for the coming rising edge and checks the bus.
  task automatic serve();
    logic [31:0] off;
    if (pend_wr && reset) mem[pend_idx] = pend_data;
    pend_wr = 1'b0;
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] = img[i];
      stalled_prev = 1'b0;
      waitrequest  = 1'b0;
      readdata     = 32'd0;
      stall_left   = reload();
    end else begin
      check("rw_excl", 96'(read && write), 96'd0);
      if (stalled_prev)
        check("stall_hold", 96'({address, writedata, byteenable, read, write}), 96'(prev_bus));
      if (read || write) begin
        off = address - RV;
        check("bus_addr", 96'({off[31:10], off[1:0]}), 96'd0);
        if (stall_left > 0) begin
          waitrequest = 1'b1;
          stall_left--;
          readdata = $urandom;
        end else begin
          waitrequest = 1'b0;
          if (write) begin
            check("sw_be", 96'(byteenable), 96'hF);
            pend_wr   = 1'b1;
            pend_idx  = int'(off[9:2]);
            pend_data = writedata;
          end
          readdata   = read ? mem[off[9:2]] : $urandom;
          stall_left = reload();
        end
      end else begin
        waitrequest = 1'b0;
        readdata    = $urandom;
      end
      stalled_prev = (read || write) && waitrequest;
      prev_bus     = {address, writedata, byteenable, read, write};
    end
  endtask

  task automatic tick();
    @(negedge clk);
    serve();
  endtask

  function automatic logic [31:0] enc_r(input int s, input int t, input int d, input int sh,
                                         input int fn);
    return {6'd0, s[4:0], t[4:0], d[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int s, input int t, input int imm);
    return {op[5:0], s[4:0], t[4:0], imm[15:0]};
  endfunction

  function automatic int pick_dst();
    int r = rnd(0, 31);
    return (r == 3) ? 2 : r;
  endfunction

  function automatic logic [31:0] gen_alu();
    int rfn [14] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h21, 'h23, 'h24, 'h25, 'h26, 'h2a,
                     'h2b, 'h20};
    int iop [8] = '{'h09, 'h0a, 'h0b, 'h0c, 'h0d, 'h0e, 'h0f, 'h08};
    int off = 'h200 + 4 * rnd(0, 95) + rnd(0, 3);
    case (rnd(0, 4))
      0, 1: return enc_r(rnd(0, 31), rnd(0, 31), pick_dst(), rnd(0, 31), rfn[rnd(0, 13)]);
      2, 3: return enc_i(iop[rnd(0, 7)], rnd(0, 31), pick_dst(), rnd(0, 65535));
      default: return (rnd(0, 1) == 1) ? enc_i('h23, 3, pick_dst(), off)
                                       : enc_i('h2b, 3, rnd(0, 31), off);
    endcase
  endfunction

  // Random forward-only program: body, dump of $1..$31 to the top of memory, then jr $0.
  task automatic gen_program();
    int          i = 1;
    int          tgt;
    logic [31:0] ja;
    for (int k = 0; k < 128; k++) img[k] = 32'd0;
    for (int k = 128; k < 256; k++) img[k] = $urandom;
    img[0] = enc_i('h0f, 0, 3, 'hBFC0);
    while (i <= 40) begin
      if (i < 40 && rnd(0, 5) == 0) begin
        tgt = i + 2 + rnd(0, 5);
        ja  = (RV >> 2) + 32'(tgt);
        case (rnd(0, 2))
          0:       img[i] = enc_i('h04, rnd(0, 31), rnd(0, 31), tgt - (i + 1));
          1:       img[i] = enc_i('h05, rnd(0, 31), rnd(0, 31), tgt - (i + 1));
          default: img[i] = {6'h03, ja[25:0]};
        endcase
        img[i + 1] = gen_alu();
        i += 2;
      end else begin
        img[i] = gen_alu();
        i++;
      end
    end
    for (int r = 1; r < 32; r++) img[40 + r] = enc_i('h2b, 3, r, 'h380 + 4 * (r - 1));
    img[72] = enc_r(0, 0, 0, 0, 'h08);
  endtask

  // Instruction-level reference: one loop iteration per instruction, delay slot via (pc, npc).
  task automatic run_model();
    logic [31:0] pc, npc, nxt, ins, a, b, se, res, ea;
    logic [4:0]  wa;
    logic        wen;
    int          steps = 0;
    for (int k = 0; k < 256; k++) mdl_mem[k] = img[k];
    for (int k = 0; k < 32; k++) mdl_reg[k] = 32'd0;
    pc  = RV;
    npc = RV + 4;
    while (pc != 32'd0 && steps < 4000) begin
      ins = mdl_mem[8'((pc - RV) >> 2)];
      a   = mdl_reg[ins[25:21]];
      b   = mdl_reg[ins[20:16]];
      se  = {{16{ins[15]}}, ins[15:0]};
      ea  = (a + se) & ~32'd3;
      nxt = npc + 4;
      wen = 1'b1;
      wa  = ins[20:16];
      res = 32'd0;
      case (ins[31:26])
        6'h00: begin
          wa = ins[15:11];
          case (ins[5:0])
            6'h00: res = b << ins[10:6];
            6'h02: res = b >> ins[10:6];
            6'h03: res = $signed(b) >>> ins[10:6];
            6'h04: begin res = b << a[4:0]; wen = VarShift; end
            6'h06: begin res = b >> a[4:0]; wen = VarShift; end
            6'h07: begin res = $signed(b) >>> a[4:0]; wen = VarShift; end
            6'h08: begin wen = 1'b0; nxt = a; end
            6'h09: begin res = pc + 8; nxt = a; end
            6'h21: res = a + b;
            6'h23: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h26: res = a ^ b;
            6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2b: res = (a < b) ? 32'd1 : 32'd0;
            default: wen = 1'b0;
          endcase
        end
        6'h02: begin wen = 1'b0; nxt = {npc[31:28], ins[25:0], 2'b00}; end
        6'h03: begin wa = 5'd31; res = pc + 8; nxt = {npc[31:28], ins[25:0], 2'b00}; end
        6'h04: begin wen = 1'b0; if (a == b) nxt = npc + (se << 2); end
        6'h05: begin wen = 1'b0; if (a != b) nxt = npc + (se << 2); end
        6'h09: res = a + se;
        6'h0a: res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0b: res = (a < se) ? 32'd1 : 32'd0;
        6'h0c: res = a & {16'd0, ins[15:0]};
        6'h0d: res = a | {16'd0, ins[15:0]};
        6'h0e: res = a ^ {16'd0, ins[15:0]};
        6'h0f: res = {ins[15:0], 16'd0};
        6'h23: res = mdl_mem[8'((ea - RV) >> 2)];
        6'h2b: begin wen = 1'b0; mdl_mem[8'((ea - RV) >> 2)] = b; end
        default: wen = 1'b0;
      endcase
      if (wen && wa != 5'd0) mdl_reg[wa] = res;
      pc  = npc;
      npc = nxt;
      steps++;
    end
  endtask

  task automatic load_shift_prog(input logic [31:0] val, input logic [31:0] amt);
    for (int k = 0; k < 256; k++) img[k] = 32'd0;
    img[0]  = enc_i('h0f, 0, 3, 'hBFC0);
    img[1]  = enc_i('h23, 3, 9, 'h28);
    img[2]  = enc_i('h23, 3, 10, 'h2C);
    img[3]  = enc_r(0, 0, 0, 0, 'h08);
    img[4]  = enc_r(10, 9, 2, 0, 'h07);
    img[10] = val;
    img[11] = amt;
  endtask

  task automatic load_sum_prog();
    for (int k = 0; k < 256; k++) img[k] = 32'd0;
    img[0] = enc_i('h0f, 0, 3, 'hBFC0);
    img[1] = enc_i('h09, 0, 2, 5);
    img[2] = enc_i('h2b, 3, 2, 'h40);
    img[3] = enc_i('h23, 3, 4, 'h40);
    img[4] = enc_r(2, 4, 2, 0, 'h21);
    img[5] = enc_r(0, 0, 0, 0, 'h08);
  endtask

  task automatic start_run(input int mode);
    stall_mode = mode;
    reset = 1'b0;
    tick();
    tick();
    check("rst_active", 96'(active), 96'd0);
    check("rst_rw", 96'({read, write}), 96'd0);
    check("rst_addr", 96'(address), 96'(RV));
    check("rst_be_wd", 96'({byteenable, writedata}), 96'({4'hF, 32'd0}));
    check("rst_v0", 96'(register_v0), 96'd0);
    #1 reset = 1'b1;
    #1;
    check("rel_fetch", 96'({active, read, write, byteenable, address}),
          96'({1'b1, 1'b1, 1'b0, 4'hF, RV}));
    serve();
  endtask

  task automatic finish_run(input logic [31:0] exp_v0);
    int n = 0;
    while (active && n < 20000) begin
      tick();
      n++;
    end
    check("halt_reached", 96'(active), 96'd0);
    check("final_v0", 96'(register_v0), 96'(exp_v0));
    check("halt_bus", 96'({read, write}), 96'd0);
    repeat (5) tick();
    check("halt_hold", 96'({active, register_v0}), 96'({1'b0, exp_v0}));
  endtask

  initial begin
    load_shift_prog(32'h000000C0, 32'd5);
    start_run(0);
    finish_run(VarShift ? 32'd6 : 32'd0);

    load_shift_prog(32'h80000000, 32'd4);
    start_run(0);
    finish_run(VarShift ? 32'hF8000000 : 32'd0);

    load_shift_prog(32'h80000000, 32'd4);
    start_run(1);
    finish_run(VarShift ? 32'hF8000000 : 32'd0);

    load_sum_prog();
    start_run(0);
    finish_run(32'd10);
    check("sw_data", 96'(mem[16]), 96'd5);

    load_sum_prog();
    start_run(1);
    finish_run(32'd10);
    check("sw_data_wait", 96'(mem[16]), 96'd5);

    // Abort the store in flight, then rerun from the reset vector.
    load_sum_prog();
    start_run(0);
    repeat (6) tick();
    check("pre_rst", 96'({register_v0, write}), 96'({32'd5, 1'b1}));
    #3 reset = 1'b0;
    #1 check("mid_rst", 96'({active, read, write, register_v0, address}),
             96'({3'b000, 32'd0, RV}));
    start_run(0);
    finish_run(32'd10);

    for (int k = 0; k < 6; k++) begin
      gen_program();
      run_model();
      start_run(k % 3);
      finish_run(mdl_reg[2]);
      for (int i = 128; i < 256; i++) check("mem_word", 96'(mem[i]), 96'(mdl_mem[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus.md
MIPS_CPU_BUS -- requirements
Module: mips_cpu_bus

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, first instruction fetch address.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = held in reset).
REQ-004 SHALL have port active  output  1  high while executing; low in reset and after halt.
REQ-005 SHALL have port register_v0  output  32  live copy of register $2.
REQ-006 SHALL have ports address output 32 (byte address, word-aligned), write output 1, read output 1, waitrequest input 1, writedata output 32, byteenable output 4, readdata input 32.

Function
REQ-007 SHALL be a multicycle CPU with states FETCH, EXEC, MEM, HALT and one memory access in flight at most.
REQ-008 FETCH SHALL drive read=1, write=0, address=PC, byteenable=4'b1111; the instruction is latched on the edge where waitrequest=0, then EXEC.
REQ-009 While read or write is high and waitrequest=1, address, writedata, byteenable, read and write SHALL stay unchanged and the state SHALL not advance.
REQ-010 read and write SHALL never be high together; both SHALL be 0 in EXEC and HALT.
REQ-011 EXEC SHALL decode, compute ALU results, write rd/rt for non-memory instructions, update PC, then return to FETCH; LW/SW go to MEM.
REQ-012 MEM SHALL drive address=rs+sign-extended offset, byteenable=4'b1111; LW writes readdata into rt on the completing edge; SW drives writedata=rt with write=1.
REQ-013 Supported: ADDU SUBU AND OR XOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV JR JALR ADDIU ANDI ORI XORI SLTI SLTIU LUI LW SW BEQ BNE J JAL; all others SHALL execute as NOP.
REQ-014 Variable shifts SHALL use rs[4:0] as amount; SRAV/SRA replicate bit 31; ANDI/ORI/XORI zero-extend, others sign-extend; no overflow traps.
REQ-015 Writes to $0 SHALL be discarded; $0 reads as 0.
REQ-016 Branches/jumps SHALL have one delay slot: the following instruction always executes, then PC becomes the target; JAL/JALR link PC+8.
REQ-017 When PC == 32'h00000000 at entry to FETCH, CPU SHALL enter HALT instead of fetching: active=0, read=0, write=0, registers frozen.
REQ-018 HALT SHALL be left only by reset.
REQ-019 Misaligned LW/SW addresses SHALL be accessed with the low two bits forced to 0.

Reset
REQ-020 While reset=0 (asynchronous): PC=RESET_VECTOR, state=FETCH, all 32 registers=0, active=0, read=0, write=0, address=RESET_VECTOR, byteenable=4'b1111, writedata=0.
REQ-021 After reset rises, active SHALL be 1 and the first FETCH to RESET_VECTOR SHALL be visible on the bus before the next rising clk edge.
REQ-022 Reset asserted mid-access SHALL abort the access immediately; no register write from it.

Configuration
REQ-023 Macro MIPS_VAR_SHIFT_EN: defined -> SLLV/SRLV/SRAV implemented per REQ-014; undefined -> those three opcodes execute as NOP (rd unchanged).

Verification
REQ-024 Reset pulse then release -> before next rising edge: active=1, address=BFC00000, read=1, write=0, byteenable=1111.
REQ-025 Program lui $3,0xBFC0; lw $9,0x28($3); lw $10,0x2C($3); jr $0; srav $2,$9,$10 with words 0xC0 and 0x05 -> active falls, register_v0=6 (MIPS_VAR_SHIFT_EN defined).
REQ-026 Same program with data 0x80000000 and 4 -> register_v0=0xF8000000; without MIPS_VAR_SHIFT_EN -> register_v0=0.
REQ-027 RAM asserting waitrequest 3 cycles per access -> bus outputs stable during stalls; same final register_v0 as zero-wait run.
REQ-028 addiu $2,$0,5; sw $2,0x40($3); lw $4,0x40($3); addu $2,$2,$4; jr $0; nop -> write seen with byteenable=1111, register_v0=10.
REQ-029 Reset asserted mid-program -> active=0 and register_v0=0 immediately, restart fetch at BFC00000 after release.
